// File: rtl/spi_master_if.sv
// Bus bundle for the mode-0 SPI master: controller handshake plus the SPI pins.
// The master modport is the spi_master side; the slave modport is the controller/bus side.
interface spi_master_if;
  logic       start;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       busy;
  logic       done;
  logic       SCLK;
  logic       CS;
  logic       MOSI;
  logic       MISO;

  modport master (
    input  start, tx_data, MISO,
    output rx_data, busy, done, SCLK, CS, MOSI
  );

  modport slave (
    output start, tx_data, MISO,
    input  rx_data, busy, done, SCLK, CS, MOSI
  );
endinterface

// File: rtl/spi_master.sv
// Mode-0 (CPOL=0, CPHA=0) 8-bit MSB-first SPI master with start/done handshake.
// Optional back-to-back bytes without releasing CS: define SPI_MASTER_BURST_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | CS high, SCLK low, waiting for start
// ST_SETUP | CS low, first MOSI bit presented, one half-period before SCLK rises
// ST_RUN   | 16 SCLK half-periods; sample MISO on rises, shift MOSI on falls
// ST_HOLD  | one half-period with SCLK low after the last fall, then done
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_master_if.master bus
);

  localparam int                DIV_W     = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam int                HALF_W    = $clog2(2 * DATA_W);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]        state;
  logic [DIV_W-1:0]  div_cnt;
  logic [HALF_W-1:0] half_cnt;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] rx_q;
  logic              sclk_q;
  logic              cs_q;
  logic              mosi_q;
  logic              busy_q;
  logic              done_q;
  logic              tick;
  logic              burst_go;

  assign tick = (div_cnt == DIV_LAST);

`ifdef SPI_MASTER_BURST_EN
  assign burst_go = bus.start;
`else
  assign burst_go = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      div_cnt  <= '0;
      half_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rx_q     <= '0;
      sclk_q   <= 1'b0;
      cs_q     <= 1'b1;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Divider free-runs while busy and wraps to 0 on every half-period tick,
      // so it is already 0 whenever the FSM returns to IDLE or re-enters SETUP.
      if (state != ST_IDLE) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            tx_sr    <= bus.tx_data;
            mosi_q   <= bus.tx_data[DATA_W-1];
            cs_q     <= 1'b0;
            busy_q   <= 1'b1;
            div_cnt  <= '0;
            half_cnt <= '0;
            state    <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (tick) begin
            sclk_q   <= 1'b1;
            rx_sr    <= {rx_sr[DATA_W-2:0], bus.MISO};
            half_cnt <= HALF_W'(1);
            state    <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (tick) begin
            half_cnt <= half_cnt + 1'b1;
            if (half_cnt[0]) begin
              sclk_q <= 1'b0;
              if (half_cnt == HALF_LAST) begin
                mosi_q <= 1'b0;
                state  <= ST_HOLD;
              end else begin
                tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
                mosi_q <= tx_sr[DATA_W-2];
              end
            end else begin
              sclk_q <= 1'b1;
              rx_sr  <= {rx_sr[DATA_W-2:0], bus.MISO};
            end
          end
        end

        ST_HOLD: begin
          if (tick) begin
            done_q <= 1'b1;
            rx_q   <= rx_sr;
            if (burst_go) begin
              tx_sr    <= bus.tx_data;
              mosi_q   <= bus.tx_data[DATA_W-1];
              half_cnt <= '0;
              state    <= ST_SETUP;
            end else begin
              cs_q   <= 1'b1;
              busy_q <= 1'b0;
              state  <= ST_IDLE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.SCLK    = sclk_q;
  assign bus.CS      = cs_q;
  assign bus.MOSI    = mosi_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_q;

endmodule

// File: tb/tb_spi_master.sv
// Randomized bench for spi_master at CLK_DIV=4 and CLK_DIV=2 against a timing/data
// reference model: every transfer is predicted from the accept edge by arithmetic.
`timescale 1ns/1ps
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic       rst_v     [2];
  logic       start_v   [2];
  logic [7:0] tx_v      [2];
  logic [7:0] slave_v   [2];
  logic       glitch_v  [2];

  int         dones_a   [2];
  int         accepts_a [2];
  int         rises_a   [2];
  int         e0_a      [2];
  int         last_done_a [2];
  logic       in_xfer_a [2];
  logic       prev_busy_a [2];
  logic       prev_cs_a [2];
  logic       prev_sclk_a [2];
  logic [7:0] exp_tx_a  [2];
  logic [7:0] exp_rx_a  [2];
  logic [7:0] mosi_acc_a [2];

  // {SCLK, CS, MOSI, busy, done, rx_data}
  wire [12:0] st_w [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int D = (g == 0) ? 4 : 2;

    spi_master_if bus ();

    spi_master #(.CLK_DIV(D), .DATA_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_v[g]),
      .bus   (bus)
    );

    assign bus.start   = start_v[g];
    assign bus.tx_data = tx_v[g];
    assign st_w[g] = {bus.SCLK, bus.CS, bus.MOSI, bus.busy, bus.done, bus.rx_data};

    // Reference model: from the accept edge E0, SCLK rise k is at E0+(2k+1)*D,
    // done at E0+17*D; MISO is only meaningful in the cycle before each rise.
    always begin : mon
      int   off;
      logic bexp;
      @(posedge clk);
      #1;
      if (!rst_v[g]) begin
        in_xfer_a[g]   = 1'b0;
        rises_a[g]     = 0;
        prev_busy_a[g] = 1'b0;
        prev_cs_a[g]   = 1'b1;
        prev_sclk_a[g] = 1'b0;
        bus.MISO       = 1'b0;
      end else begin
`ifdef SPI_MASTER_BURST_EN
        bexp = start_v[g];
`else
        bexp = 1'b0;
`endif
        if (bus.done) begin
          dones_a[g]++;
          last_done_a[g] = cyc;
          chk("cs_at_done", bus.CS, !bexp);
          chk("busy_at_done", bus.busy, bexp);
          if (in_xfer_a[g]) begin
            chk("done_latency", cyc - e0_a[g], 17 * D);
            chk("sclk_pulses", rises_a[g], 8);
            chk("mosi_byte", mosi_acc_a[g], exp_tx_a[g]);
            chk("rx_data", bus.rx_data, exp_rx_a[g]);
          end
          in_xfer_a[g] = 1'b0;
        end
        if (bus.busy && (!prev_busy_a[g] || bus.done)) begin
          if (!prev_busy_a[g]) chk("cs_gap", prev_cs_a[g], 1'b1);
          chk("cs_low_accept", bus.CS, 1'b0);
          accepts_a[g]++;
          e0_a[g]       = cyc;
          in_xfer_a[g]  = 1'b1;
          rises_a[g]    = 0;
          mosi_acc_a[g] = 8'h00;
          exp_tx_a[g]   = tx_v[g];
          exp_rx_a[g]   = slave_v[g];
        end
        if (in_xfer_a[g] && bus.SCLK && !prev_sclk_a[g]) begin
          chk("rise_time", cyc - e0_a[g], (2 * rises_a[g] + 1) * D);
          mosi_acc_a[g] = {mosi_acc_a[g][6:0], bus.MOSI};
          rises_a[g]++;
        end
        off = cyc + 1 - e0_a[g];
        if (in_xfer_a[g] && off > 0 && (off % D) == 0 && ((off / D) % 2) == 1 && (off / D) <= 15)
          bus.MISO = exp_rx_a[g][7 - ((off / D) - 1) / 2];
        else
          bus.MISO = glitch_v[g] ? 1'($urandom_range(1, 0)) : 1'b1;
        prev_busy_a[g] = bus.busy;
        prev_cs_a[g]   = bus.CS;
        prev_sclk_a[g] = bus.SCLK;
      end
    end
  end

  task automatic xfer(input int g, input logic [7:0] tx, input logic [7:0] sl);
    int d0;
    d0 = dones_a[g];
    @(negedge clk);
    tx_v[g] = tx; slave_v[g] = sl; start_v[g] = 1'b1;
    @(negedge clk);
    start_v[g] = 1'b0;
    for (int i = 0; i < 200 && dones_a[g] == d0; i++) begin
      @(negedge clk);
      tx_v[g] = 8'($urandom);
      if (g == 1 && tx == 8'h00 && dones_a[g] == d0) chk("mosi_zero", st_w[g][10], 1'b0);
    end
    chk("xfer_done_count", dones_a[g] - d0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rx_hold", st_w[g][7:0], sl);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d0, a0, t_first, d1;
    for (int g = 0; g < 2; g++) begin
      rst_v[g] = 1'b0; start_v[g] = 1'b0; tx_v[g] = 8'h00; slave_v[g] = 8'h00;
      dones_a[g] = 0; accepts_a[g] = 0; rises_a[g] = 0; e0_a[g] = 0; last_done_a[g] = 0;
      in_xfer_a[g] = 1'b0;
    end
    glitch_v[0] = 1'b1;
    glitch_v[1] = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_held0", 32'(st_w[0]), 32'h0800);
    chk("reset_held1", 32'(st_w[1]), 32'h0800);
    rst_v[0] = 1'b1; rst_v[1] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle0", 32'(st_w[0]), 32'h0800);
      if (i % 25 == 0) chk("idle1", 32'(st_w[1]), 32'h0800);
    end

    xfer(0, 8'hA5, 8'h3C);
    for (int i = 0; i < 6; i++) xfer(0, 8'($urandom), 8'($urandom));

    // start held high: re-sampled only in IDLE
    d0 = dones_a[0]; a0 = accepts_a[0]; t_first = 0;
    @(negedge clk);
    tx_v[0] = 8'hFF; slave_v[0] = 8'($urandom); start_v[0] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (accepts_a[0] == a0 + 1 && t_first == 0) t_first = e0_a[0];
    end
    start_v[0] = 1'b0;
    chk("held_accepts", accepts_a[0] - a0, 3);
`ifdef SPI_MASTER_BURST_EN
    chk("held_span", e0_a[0] - t_first, 2 * (17 * 4));
`else
    chk("held_span", e0_a[0] - t_first, 2 * (17 * 4 + 1));
`endif
    for (int i = 0; i < 200 && dones_a[0] < d0 + 3; i++) @(negedge clk);
    chk("held_dones", dones_a[0] - d0, 3);
    repeat (2) @(negedge clk);

    // reset at the 4th SCLK rise
    d0 = dones_a[0];
    @(negedge clk);
    tx_v[0] = 8'($urandom); slave_v[0] = 8'($urandom); start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    for (int i = 0; i < 200 && !(in_xfer_a[0] && rises_a[0] == 4); i++) begin
      @(posedge clk); #2;
    end
    chk("reached_rise4", rises_a[0], 4);
    rst_v[0] = 1'b0;
    #1;
    chk("mid_reset_state", 32'(st_w[0]), 32'h0800);
    repeat (3) @(negedge clk);
    rst_v[0] = 1'b1;
    repeat (100) @(negedge clk);
    chk("no_done_after_reset", dones_a[0] - d0, 0);
    chk("rx_cleared", st_w[0][7:0], 8'h00);
    xfer(0, 8'h81, 8'($urandom));

    // CLK_DIV=2, MISO high
    xfer(1, 8'h00, 8'hFF);
    for (int i = 0; i < 3; i++) xfer(1, 8'($urandom), 8'($urandom));

`ifdef SPI_MASTER_BURST_EN
    d0 = dones_a[0]; a0 = accepts_a[0];
    @(negedge clk);
    tx_v[0] = 8'h12; slave_v[0] = 8'($urandom); start_v[0] = 1'b1;
    @(negedge clk);
    tx_v[0] = 8'h34; slave_v[0] = 8'($urandom);
    for (int i = 0; i < 200 && accepts_a[0] < a0 + 2; i++) begin
      @(negedge clk);
      if (accepts_a[0] < a0 + 2) chk("burst_cs_low", st_w[0][11], 1'b0);
    end
    start_v[0] = 1'b0;
    d1 = last_done_a[0];
    for (int i = 0; i < 200 && dones_a[0] < d0 + 2; i++) begin
      @(negedge clk);
      if (dones_a[0] < d0 + 2) chk("burst_cs_low2", st_w[0][11], 1'b0);
    end
    chk("burst_dones", dones_a[0] - d0, 2);
    chk("burst_spacing", last_done_a[0] - d1, 68);
    repeat (2) @(negedge clk);
`else
    d1 = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Mode-0 SPI master (CPOL=0, CPHA=0) with an 8-bit, MSB-first full-duplex transfer per start request.
- Generates SCLK, CS and MOSI from the system clock and captures MISO into rx_data.
- Acts as the initiator that drives the team's SPI slave font/register peripheral.
- Sits between a local controller (start/done handshake) and the off-chip or on-chip SPI bus.

Parameters:
- CLK_DIV, 4: system clocks per SCLK half-period; legal range 2..255.
- DATA_W, 8: transfer length in bits; fixed at 8 for this release and shown for documentation only.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  transfer request; sampled only in IDLE.
- tx_data  input  8  byte to send; captured on the start-accept edge.
- rx_data  output  8  last received byte; updates on the done edge.
- busy  output  1  high from the accept edge until the done edge.
- done  output  1  one-clock pulse at end of transfer.
- SCLK  output  1  SPI clock; idles low.
- CS  output  1  active-low chip select; idles high.
- MOSI  output  1  master data out.
- MISO  input  1  slave data in.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; SCLK=0, CS=1, MOSI=0, busy=0, done=0, rx_data=8'h00.
  - Shift and divider counters cleared.
- States: IDLE, SETUP, RUN, HOLD.
- IDLE: at edge E0 with start=1:
  - tx shift register <= tx_data.
  - CS <= 0, busy <= 1, MOSI <= tx_data[7].
  - Go to SETUP.
- SETUP: CLK_DIV cycles with SCLK low and CS low, then go to RUN.
- RUN: 16 half-periods of CLK_DIV cycles each.
  - Rising edge k (k=0..7) at E0+(2k+1)*CLK_DIV: SCLK <= 1; capture MISO into the rx shift register LSB (shift left).
  - Falling edge k at E0+(2k+2)*CLK_DIV: SCLK <= 0.
  - For k<7, MOSI <= next tx bit.
  - After the 8th falling edge (E0+16*CLK_DIV), go to HOLD.
- HOLD: CLK_DIV cycles with SCLK=0, CS=0, MOSI=0. At E0+17*CLK_DIV, all in one edge:
  - CS <= 1, busy <= 0, done <= 1 for one cycle.
  - rx_data <= rx shift register.
  - Go to IDLE.
- Latency: done rises 17*CLK_DIV clocks after the accept edge (68 at default).
- start while busy, or in the done cycle, is ignored; a new transfer is accepted no earlier than the edge after done.
- tx_data changes after accept have no effect on the transfer in flight.
- rx_data is stable between done pulses; it is never partially updated.
- Reset mid-transfer: CS goes high and SCLK low immediately (async); no done pulse; rx_data=0.
- MISO is sampled only on SCLK-rising system edges; glitches elsewhere are ignored.
- Divider counter width is ceil(log2(CLK_DIV)); it wraps to 0 at CLK_DIV-1.

Optional Feature:
- Macro: SPI_MASTER_BURST_EN.
- Defined: if start=1 on the HOLD-exit edge, the next byte runs without releasing CS.
  - CS stays 0 and busy stays 1; done still pulses and rx_data still updates.
  - tx_data is captured and MOSI <= tx_data[7] on that edge.
  - The FSM enters SETUP directly, so the next SCLK rise occurs CLK_DIV clocks later.
- Not defined: start on that edge is ignored; CS always deasserts between bytes (at least one clock high).

Test Plan:
- Reset held then released, no start -> SCLK=0, CS=1, MOSI=0, busy=0, done=0, rx_data=8'h00 for 100 clocks.
- tx_data=8'hA5, slave model returns 8'h3C, CLK_DIV=4 -> MOSI bits 1,0,1,0,0,1,0,1 stable at each SCLK rise; exactly 8 SCLK pulses of 8-clock period; done at E0+68; rx_data=8'h3C; CS high at the done edge.
- start held high for 200 clocks with tx_data=8'hFF -> start re-sampled only in IDLE; second transfer accepted the edge after the first done; start pulses during busy are not accepted; CS high for at least one clock between bytes (burst disabled).
- rst_n pulled low at the 4th SCLK rise of a transfer -> CS=1 and SCLK=0 asynchronously; no done; rx_data=8'h00; a fresh transfer after release of 8'h81 completes correctly.
- CLK_DIV=2, tx_data=8'h00, MISO tied 1 -> done at E0+34; rx_data=8'hFF; MOSI=0 throughout.
- With SPI_MASTER_BURST_EN, start high at the first done, tx 8'h12 then 8'h34 -> CS never rises between bytes; two done pulses 68 clocks apart; rx_data updated twice.
